// File: rtl/square_motion_pkg.sv
// Shared constants and encodings for the bouncing-square motion engine.
package square_motion_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned TICK_ROW = 481;
  localparam int unsigned COORD_W  = 10;
  // One extra bit so pos+STEP never wraps before the limit compare.
  localparam int unsigned CALC_W   = COORD_W + 1;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_e;

endpackage

// File: rtl/square_motion_if.sv
// Scan inputs from vga_controller and square outputs towards pixel_generation.
interface square_motion_if;
  import square_motion_pkg::*;

  logic               video_on;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               pause;
  logic               sq_on;
  logic [COORD_W-1:0] sq_x;
  logic [COORD_W-1:0] sq_y;
  logic               frame_tick;
  logic [15:0]        bounce_cnt;

  modport master (
    output video_on, x, y, pause,
    input  sq_on, sq_x, sq_y, frame_tick, bounce_cnt
  );

  modport slave (
    input  video_on, x, y, pause,
    output sq_on, sq_x, sq_y, frame_tick, bounce_cnt
  );

endinterface

// File: rtl/square_motion_axis_bounce.sv
// One axis of square motion: step towards the current direction, reflecting at 0 and lim.
module axis_bounce
  import square_motion_pkg::*;
(
  input  logic [COORD_W-1:0] pos,
  input  dir_e               dir,
  input  logic [CALC_W-1:0]  step,
  input  logic [CALC_W-1:0]  lim,
  output logic [COORD_W-1:0] next_pos,
  output dir_e               next_dir,
  output logic               bounce
);

  logic [CALC_W-1:0] pos_w;
  logic [CALC_W-1:0] sum_w;

  always_comb begin
    pos_w    = {1'b0, pos};
    sum_w    = pos_w + step;
    next_pos = pos;
    next_dir = dir;
    bounce   = 1'b0;
    if (dir == DIR_POS) begin
      if (sum_w >= lim) begin
        next_pos = lim[COORD_W-1:0];
        next_dir = DIR_NEG;
        bounce   = 1'b1;
      end else begin
        next_pos = sum_w[COORD_W-1:0];
      end
    end else begin
      if (pos_w <= step) begin
        next_pos = '0;
        next_dir = DIR_POS;
        bounce   = 1'b1;
      end else begin
        next_pos = pos - step[COORD_W-1:0];
      end
    end
  end

endmodule

// File: rtl/square_motion.sv
// Bouncing-square motion engine: frame tick detect, frame divider, update/commit FSM, in-square flag.
module square_motion
  import square_motion_pkg::*;
#(
  parameter int unsigned SQ_SIZE   = 64,
  parameter int unsigned STEP      = 1,
  parameter int unsigned INIT_X    = 288,
  parameter int unsigned INIT_Y    = 208,
  parameter int unsigned FRAME_DIV = 1
) (
  input  logic            clk,
  input  logic            reset,
  square_motion_if.slave  bus
);

  localparam logic [CALC_W-1:0]  LIM_X    = CALC_W'(H_ACTIVE - SQ_SIZE);
  localparam logic [CALC_W-1:0]  LIM_Y    = CALC_W'(V_ACTIVE - SQ_SIZE);
  localparam logic [CALC_W-1:0]  STEP_W   = CALC_W'(STEP);
  localparam logic [CALC_W-1:0]  SIZE_W   = CALC_W'(SQ_SIZE);
  localparam logic [COORD_W-1:0] INIT_X_W = COORD_W'(INIT_X);
  localparam logic [COORD_W-1:0] INIT_Y_W = COORD_W'(INIT_Y);
  localparam logic [COORD_W-1:0] ROW_W    = COORD_W'(TICK_ROW);
  localparam logic [7:0]         DIV_LAST = 8'(FRAME_DIV - 1);

  logic               row_hit_q, row_hit_d;
  logic               row_hit_dly_q, row_hit_dly_d;
  logic               frame_tick;
  logic [7:0]         div_q, div_d;
  logic               move_tick;
  state_e             state_q, state_d;
  logic [COORD_W-1:0] sq_x_q, sq_x_d, sq_y_q, sq_y_d;
  dir_e               dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [15:0]        bounce_cnt_q, bounce_cnt_d;
  logic [COORD_W-1:0] sh_x_q, sh_x_d, sh_y_q, sh_y_d;
  dir_e               sh_dir_x_q, sh_dir_x_d, sh_dir_y_q, sh_dir_y_d;
  logic [15:0]        sh_cnt_q, sh_cnt_d;
  logic               sq_on_q, sq_on_d;

  logic [COORD_W-1:0] nx_pos, ny_pos;
  dir_e               nx_dir, ny_dir;
  logic               bounce_x, bounce_y;

  axis_bounce u_axis_x (
    .pos      (sq_x_q),
    .dir      (dir_x_q),
    .step     (STEP_W),
    .lim      (LIM_X),
    .next_pos (nx_pos),
    .next_dir (nx_dir),
    .bounce   (bounce_x)
  );

  axis_bounce u_axis_y (
    .pos      (sq_y_q),
    .dir      (dir_y_q),
    .step     (STEP_W),
    .lim      (LIM_Y),
    .next_pos (ny_pos),
    .next_dir (ny_dir),
    .bounce   (bounce_y)
  );

  always_comb begin
    row_hit_d     = (bus.y == ROW_W);
    row_hit_dly_d = row_hit_q;
    frame_tick    = row_hit_q & ~row_hit_dly_q;

    div_d     = div_q;
    move_tick = 1'b0;
    if (frame_tick && !bus.pause) begin
      if (div_q >= DIV_LAST) begin
        div_d     = '0;
        move_tick = 1'b1;
      end else begin
        div_d = div_q + 8'd1;
      end
    end

    state_d      = state_q;
    sq_x_d       = sq_x_q;
    sq_y_d       = sq_y_q;
    dir_x_d      = dir_x_q;
    dir_y_d      = dir_y_q;
    bounce_cnt_d = bounce_cnt_q;
    sh_x_d       = sh_x_q;
    sh_y_d       = sh_y_q;
    sh_dir_x_d   = sh_dir_x_q;
    sh_dir_y_d   = sh_dir_y_q;
    sh_cnt_d     = sh_cnt_q;

    // Ticks seen outside WAIT are dropped; the divider still advances.
    unique case (state_q)
      ST_WAIT: begin
        if (move_tick) state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        sh_x_d     = nx_pos;
        sh_y_d     = ny_pos;
        sh_dir_x_d = nx_dir;
        sh_dir_y_d = ny_dir;
        sh_cnt_d   = bounce_cnt_q + {15'd0, bounce_x} + {15'd0, bounce_y};
        state_d    = ST_COMMIT;
      end
      ST_COMMIT: begin
        sq_x_d       = sh_x_q;
        sq_y_d       = sh_y_q;
        dir_x_d      = sh_dir_x_q;
        dir_y_d      = sh_dir_y_q;
        bounce_cnt_d = sh_cnt_q;
        state_d      = ST_WAIT;
      end
      default: state_d = ST_WAIT;
    endcase

    sq_on_d = bus.video_on
            && (bus.x >= sq_x_q) && ({1'b0, bus.x} < ({1'b0, sq_x_q} + SIZE_W))
            && (bus.y >= sq_y_q) && ({1'b0, bus.y} < ({1'b0, sq_y_q} + SIZE_W));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_hit_q     <= 1'b0;
      row_hit_dly_q <= 1'b0;
      div_q         <= '0;
      state_q       <= ST_WAIT;
      sq_x_q        <= INIT_X_W;
      sq_y_q        <= INIT_Y_W;
      dir_x_q       <= DIR_POS;
      dir_y_q       <= DIR_POS;
      bounce_cnt_q  <= '0;
      sh_x_q        <= INIT_X_W;
      sh_y_q        <= INIT_Y_W;
      sh_dir_x_q    <= DIR_POS;
      sh_dir_y_q    <= DIR_POS;
      sh_cnt_q      <= '0;
      sq_on_q       <= 1'b0;
    end else begin
      row_hit_q     <= row_hit_d;
      row_hit_dly_q <= row_hit_dly_d;
      div_q         <= div_d;
      state_q       <= state_d;
      sq_x_q        <= sq_x_d;
      sq_y_q        <= sq_y_d;
      dir_x_q       <= dir_x_d;
      dir_y_q       <= dir_y_d;
      bounce_cnt_q  <= bounce_cnt_d;
      sh_x_q        <= sh_x_d;
      sh_y_q        <= sh_y_d;
      sh_dir_x_q    <= sh_dir_x_d;
      sh_dir_y_q    <= sh_dir_y_d;
      sh_cnt_q      <= sh_cnt_d;
      sq_on_q       <= sq_on_d;
    end
  end

  assign bus.sq_on      = sq_on_q;
  assign bus.sq_x       = sq_x_q;
  assign bus.sq_y       = sq_y_q;
  assign bus.frame_tick = frame_tick;
  assign bus.bounce_cnt = bounce_cnt_q;

endmodule

// File: tb/tb_square_motion.sv
// Directed bench for square_motion: several parameterised instances plus the axis_bounce unit.
module tb_square_motion;
  import square_motion_pkg::*;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Per-instance scan drive: 0=default, 1=edge, 2=corner, 3=divider, 4=sq_on.
  logic [9:0] ty [5];
  logic [9:0] tx [5];
  logic       tv [5];
  logic       tp [5];

  square_motion_if if_a ();
  square_motion_if if_b ();
  square_motion_if if_c ();
  square_motion_if if_d ();
  square_motion_if if_e ();

  assign if_a.y = ty[0]; assign if_a.x = tx[0]; assign if_a.video_on = tv[0]; assign if_a.pause = tp[0];
  assign if_b.y = ty[1]; assign if_b.x = tx[1]; assign if_b.video_on = tv[1]; assign if_b.pause = tp[1];
  assign if_c.y = ty[2]; assign if_c.x = tx[2]; assign if_c.video_on = tv[2]; assign if_c.pause = tp[2];
  assign if_d.y = ty[3]; assign if_d.x = tx[3]; assign if_d.video_on = tv[3]; assign if_d.pause = tp[3];
  assign if_e.y = ty[4]; assign if_e.x = tx[4]; assign if_e.video_on = tv[4]; assign if_e.pause = tp[4];

  square_motion dut_a (.clk(clk), .reset(rst_a), .bus(if_a));
  square_motion #(.INIT_X(575)) dut_b (.clk(clk), .reset(rst), .bus(if_b));
  square_motion #(.INIT_X(574), .INIT_Y(414), .STEP(2)) dut_c (.clk(clk), .reset(rst), .bus(if_c));
  square_motion #(.FRAME_DIV(3)) dut_d (.clk(clk), .reset(rst), .bus(if_d));
  square_motion #(.INIT_X(100), .INIT_Y(50)) dut_e (.clk(clk), .reset(rst), .bus(if_e));

  logic [9:0]  ab_pos, ab_next;
  dir_e        ab_dir, ab_next_dir;
  logic [10:0] ab_step, ab_lim;
  logic        ab_bounce;

  axis_bounce u_ab (
    .pos(ab_pos), .dir(ab_dir), .step(ab_step), .lim(ab_lim),
    .next_pos(ab_next), .next_dir(ab_next_dir), .bounce(ab_bounce)
  );

  int unsigned ticks_a = 0;
  int unsigned ticks_d = 0;
  always @(negedge clk) begin
    if (if_a.frame_tick) ticks_a <= ticks_a + 1;
    if (if_d.frame_tick) ticks_d <= ticks_d + 1;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1, commit has landed by then.
  task automatic do_frame(input int unsigned idx);
    ty[idx] = 10'd481;
    repeat (3) @(posedge clk);
    #1;
    ty[idx] = '0;
    repeat (5) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       vid;
    logic [9:0] x;
    logic [9:0] y;
    logic       exp_on;
  } on_vec_t;

  typedef struct {
    logic [9:0]  pos;
    logic        dir;
    logic [10:0] step;
    logic [10:0] lim;
    logic [9:0]  exp_pos;
    logic        exp_dir;
    logic        exp_bounce;
  } ab_vec_t;

  on_vec_t on_tab [8];
  ab_vec_t ab_tab [9];

  int unsigned t0;
  int          exp_x;

  initial begin
    on_tab[0] = '{1'b1, 10'd99,  10'd50,  1'b0};
    on_tab[1] = '{1'b1, 10'd100, 10'd50,  1'b1};
    on_tab[2] = '{1'b1, 10'd163, 10'd50,  1'b1};
    on_tab[3] = '{1'b1, 10'd164, 10'd50,  1'b0};
    on_tab[4] = '{1'b0, 10'd120, 10'd60,  1'b0};
    on_tab[5] = '{1'b1, 10'd120, 10'd49,  1'b0};
    on_tab[6] = '{1'b1, 10'd120, 10'd113, 1'b1};
    on_tab[7] = '{1'b1, 10'd120, 10'd114, 1'b0};

    ab_tab[0] = '{10'd1,   1'b1, 11'd2,  11'd576, 10'd0,   1'b0, 1'b1};
    ab_tab[1] = '{10'd1,   1'b1, 11'd2,  11'd416, 10'd0,   1'b0, 1'b1};
    ab_tab[2] = '{10'd575, 1'b0, 11'd1,  11'd576, 10'd576, 1'b1, 1'b1};
    ab_tab[3] = '{10'd576, 1'b1, 11'd1,  11'd576, 10'd575, 1'b1, 1'b0};
    ab_tab[4] = '{10'd574, 1'b0, 11'd1,  11'd576, 10'd575, 1'b0, 1'b0};
    ab_tab[5] = '{10'd2,   1'b1, 11'd1,  11'd576, 10'd1,   1'b1, 1'b0};
    ab_tab[6] = '{10'd1,   1'b1, 11'd1,  11'd576, 10'd0,   1'b0, 1'b1};
    ab_tab[7] = '{10'd0,   1'b0, 11'd64, 11'd576, 10'd64,  1'b0, 1'b0};
    ab_tab[8] = '{10'd512, 1'b0, 11'd64, 11'd576, 10'd576, 1'b1, 1'b1};

    for (int i = 0; i < 5; i++) begin
      ty[i] = '0; tx[i] = '0; tv[i] = 1'b0; tp[i] = 1'b0;
    end
    ab_pos = '0; ab_dir = DIR_POS; ab_step = '0; ab_lim = '0;

    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b0;
    rst   = 1'b0;

    chk("rst_sq_x", int'(if_a.sq_x), 288);
    chk("rst_sq_y", int'(if_a.sq_y), 208);
    chk("rst_bounce", int'(if_a.bounce_cnt), 0);
    chk("rst_sq_on", int'(if_a.sq_on), 0);
    chk("rst_tick", int'(if_a.frame_tick), 0);

    // First frame: pulse on the edge that first sees y=481, commit two clks later.
    t0 = ticks_a;
    ty[0] = 10'd481;
    @(posedge clk); #1;
    chk("f1_tick_hi", int'(if_a.frame_tick), 1);
    chk("f1_x_before", int'(if_a.sq_x), 288);
    @(posedge clk); #1;
    chk("f1_tick_lo", int'(if_a.frame_tick), 0);
    @(posedge clk); #1;
    chk("f1_x_update", int'(if_a.sq_x), 288);
    @(posedge clk); #1;
    chk("f1_x_commit", int'(if_a.sq_x), 289);
    chk("f1_y_commit", int'(if_a.sq_y), 209);
    repeat (3) @(posedge clk); #1;
    ty[0] = '0;
    repeat (3) @(posedge clk); #1;
    chk("f1_tick_count", int'(ticks_a - t0), 1);

    // Reset landing in UPDATE must discard the pending move.
    ty[0] = 10'd481;
    @(posedge clk); #1;
    chk("r5_tick", int'(if_a.frame_tick), 1);
    ty[0] = '0;
    @(posedge clk); #1;
    rst_a = 1'b1;
    @(posedge clk); #1;
    rst_a = 1'b0;
    chk("r5_x", int'(if_a.sq_x), 288);
    chk("r5_y", int'(if_a.sq_y), 208);
    chk("r5_bounce", int'(if_a.bounce_cnt), 0);
    repeat (4) @(posedge clk); #1;
    chk("r5_no_commit_x", int'(if_a.sq_x), 288);
    chk("r5_no_commit_y", int'(if_a.sq_y), 208);

    // Right-edge reflection.
    do_frame(1);
    chk("e2_x", int'(if_b.sq_x), 576);
    chk("e2_y", int'(if_b.sq_y), 209);
    chk("e2_bounce", int'(if_b.bounce_cnt), 1);
    do_frame(1);
    chk("e2_x_back", int'(if_b.sq_x), 575);
    chk("e2_y2", int'(if_b.sq_y), 210);
    chk("e2_bounce2", int'(if_b.bounce_cnt), 1);

    // Simultaneous hit on both far edges.
    do_frame(2);
    chk("c3_x", int'(if_c.sq_x), 576);
    chk("c3_y", int'(if_c.sq_y), 416);
    chk("c3_bounce", int'(if_c.bounce_cnt), 2);
    do_frame(2);
    chk("c3_x_back", int'(if_c.sq_x), 574);
    chk("c3_y_back", int'(if_c.sq_y), 414);
    chk("c3_bounce2", int'(if_c.bounce_cnt), 2);

    // Divider of 3 with pause.
    tp[3] = 1'b1;
    t0 = ticks_d;
    for (int f = 0; f < 5; f++) begin
      do_frame(3);
      chk("d4_paused_x", int'(if_d.sq_x), 288);
    end
    chk("d4_paused_ticks", int'(ticks_d - t0), 5);
    tp[3] = 1'b0;
    for (int f = 1; f <= 6; f++) begin
      do_frame(3);
      exp_x = 288 + f / 3;
      chk("d4_run_x", int'(if_d.sq_x), exp_x);
      chk("d4_run_y", int'(if_d.sq_y), 208 + f / 3);
    end

    // In-square flag, one clk latency.
    for (int i = 0; i < 8; i++) begin
      tv[4] = on_tab[i].vid;
      tx[4] = on_tab[i].x;
      ty[4] = on_tab[i].y;
      @(posedge clk); #1;
      chk($sformatf("sq_on[%0d]", i), int'(if_e.sq_on), int'(on_tab[i].exp_on));
    end
    tv[4] = 1'b0;

    // Axis rule in isolation, including the STEP=2 corner from 1.
    for (int i = 0; i < 9; i++) begin
      ab_pos  = ab_tab[i].pos;
      ab_dir  = dir_e'(ab_tab[i].dir);
      ab_step = ab_tab[i].step;
      ab_lim  = ab_tab[i].lim;
      #1;
      chk($sformatf("ab_pos[%0d]", i), int'(ab_next), int'(ab_tab[i].exp_pos));
      chk($sformatf("ab_dir[%0d]", i), int'(ab_next_dir), int'(ab_tab[i].exp_dir));
      chk($sformatf("ab_bounce[%0d]", i), int'(ab_bounce), int'(ab_tab[i].exp_bounce));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
